// File: rtl/ebus_arb.sv
// rtl/ebus_arb.sv - Registered N-driver EBUS arbiter: fixed priority or round-robin with hold, plus contention tracking
module ebus_arb #(
  parameter int NDRV  = 9,
  parameter int WIDTH = 36,
  parameter int RR    = 0,
  parameter int CNTW  = 8,
  localparam int OW   = (NDRV > 1) ? $clog2(NDRV) : 1
) (
  input  logic                  eboxClk,
  input  logic                  eboxResetN,
  input  logic [NDRV-1:0]       drvDriving,
  input  logic [NDRV*WIDTH-1:0] drvData,
  input  logic                  clrConflict,
  output logic [WIDTH-1:0]      ebusData,
  output logic                  ebusValid,
  output logic [OW-1:0]         ebusOwner,
  output logic                  conflict,
  output logic                  conflictSticky,
  output logic [CNTW-1:0]       conflictCount
);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     last_q, last_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic              conf_q, conf_d;
  logic              sticky_q, sticky_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic [OW-1:0]     start;
  logic [OW-1:0]     hi_idx, lo_idx, win;
  logic              hi_found, lo_found;
  logic              multi;

  // Wrapped search split in two halves: requests at or above start beat those below it.
  // In fixed-priority mode start is forced to 0 so only the upper half is ever used.
  always_comb begin
    start    = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    if (RR != 0) begin
      start = (last_q == OW'(NDRV - 1)) ? '0 : last_q + OW'(1);
    end
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (drvDriving[i]) begin
        if (OW'(i) < start) begin
          lo_found = 1'b1;
          lo_idx   = OW'(i);
        end else begin
          hi_found = 1'b1;
          hi_idx   = OW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    valid_d = 1'b0;
    win     = '0;
    if (RR != 0 && state_q == ST_OWNED && drvDriving[last_q]) begin
      valid_d = 1'b1;
      win     = last_q;
    end else if (hi_found) begin
      valid_d = 1'b1;
      win     = hi_idx;
    end else if (lo_found) begin
      valid_d = 1'b1;
      win     = lo_idx;
    end
    if (RR != 0) begin
      state_d = valid_d ? ST_OWNED : ST_IDLE;
      if (valid_d) begin
        last_d = win;
      end
    end

    data_d  = '0;
    owner_d = owner_q;
    if (valid_d) begin
      owner_d = win;
      for (int i = 0; i < NDRV; i++) begin
        if (win == OW'(i)) begin
          data_d = drvData[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Two or more requests: clearing the lowest set bit still leaves something.
  assign multi = |(drvDriving & (drvDriving - NDRV'(1)));

  always_comb begin
    conf_d   = multi;
    sticky_d = sticky_q;
    count_d  = count_q;
    if (multi) begin
      sticky_d = 1'b1;
      if (clrConflict) begin
        count_d = CNTW'(1);
      end else if (!(&count_q)) begin
        count_d = count_q + CNTW'(1);
      end
    end else if (clrConflict) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      state_q  <= ST_IDLE;
      last_q   <= OW'(NDRV - 1);
      data_q   <= '0;
      valid_q  <= 1'b0;
      owner_q  <= '0;
      conf_q   <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      conf_q   <= conf_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign ebusData       = data_q;
  assign ebusValid      = valid_q;
  assign ebusOwner      = owner_q;
  assign conflict       = conf_q;
  assign conflictSticky = sticky_q;
  assign conflictCount  = count_q;

endmodule

// File: tb/tb_ebus_arb.sv
// tb/tb_ebus_arb.sv - Directed bench for ebus_arb in fixed, round-robin and narrow-counter builds
module tb_ebus_arb;

  logic         clk;
  logic         rst_n;
  logic [8:0]   drv;
  logic [323:0] drv_data;
  logic         clr;

  logic [35:0]  f_data, r_data, s_data;
  logic         f_valid, r_valid, s_valid;
  logic [3:0]   f_owner, r_owner, s_owner;
  logic         f_conf, r_conf, s_conf;
  logic         f_sticky, r_sticky, s_sticky;
  logic [7:0]   f_cnt, r_cnt;
  logic [1:0]   s_cnt;

  logic [35:0]  dv [9];
  int           pass_cnt;
  int           total;

  ebus_arb #(.NDRV(9), .WIDTH(36), .RR(0), .CNTW(8)) u_fix (
    .eboxClk(clk), .eboxResetN(rst_n), .drvDriving(drv), .drvData(drv_data),
    .clrConflict(clr), .ebusData(f_data), .ebusValid(f_valid), .ebusOwner(f_owner),
    .conflict(f_conf), .conflictSticky(f_sticky), .conflictCount(f_cnt)
  );

  ebus_arb #(.NDRV(9), .WIDTH(36), .RR(1), .CNTW(8)) u_rr (
    .eboxClk(clk), .eboxResetN(rst_n), .drvDriving(drv), .drvData(drv_data),
    .clrConflict(clr), .ebusData(r_data), .ebusValid(r_valid), .ebusOwner(r_owner),
    .conflict(r_conf), .conflictSticky(r_sticky), .conflictCount(r_cnt)
  );

  ebus_arb #(.NDRV(9), .WIDTH(36), .RR(0), .CNTW(2)) u_sat (
    .eboxClk(clk), .eboxResetN(rst_n), .drvDriving(drv), .drvData(drv_data),
    .clrConflict(clr), .ebusData(s_data), .ebusValid(s_valid), .ebusOwner(s_owner),
    .conflict(s_conf), .conflictSticky(s_sticky), .conflictCount(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drv = '0; clr = 1'b0;
    cyc(); cyc();
    total++; if (f_data !== 36'd0) $display("FAIL reset_data got %h exp 0", f_data); else pass_cnt++;
    total++; if (f_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", f_valid); else pass_cnt++;
    total++; if (f_owner !== 4'd0) $display("FAIL reset_owner got %0d exp 0", f_owner); else pass_cnt++;
    total++; if ({f_conf, f_sticky, f_cnt} !== 10'd0) $display("FAIL reset_conflict got %h exp 0", {f_conf, f_sticky, f_cnt}); else pass_cnt++;
    total++; if ({r_valid, r_owner, r_data} !== 41'd0) $display("FAIL reset_rr got %h exp 0", {r_valid, r_owner, r_data}); else pass_cnt++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_fixed_single();
    drv = 9'b000010000;
    cyc();
    total++; if (f_data !== 36'o123456701234) $display("FAIL single_data got %o exp 123456701234", f_data); else pass_cnt++;
    total++; if (f_owner !== 4'd4) $display("FAIL single_owner got %0d exp 4", f_owner); else pass_cnt++;
    total++; if (f_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", f_valid); else pass_cnt++;
    total++; if (f_conf !== 1'b0) $display("FAIL single_conflict got %b exp 0", f_conf); else pass_cnt++;
  endtask

  task automatic test_fixed_conflict();
    drv = 9'b001000100;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (f_owner !== 4'd2) $display("FAIL conf_owner[%0d] got %0d exp 2", k, f_owner); else pass_cnt++;
      total++; if (f_data !== dv[2]) $display("FAIL conf_data[%0d] got %h exp %h", k, f_data, dv[2]); else pass_cnt++;
      total++; if (f_conf !== 1'b1) $display("FAIL conf_pulse[%0d] got %b exp 1", k, f_conf); else pass_cnt++;
      total++; if (f_cnt !== 8'(k + 1)) $display("FAIL conf_count[%0d] got %0d exp %0d", k, f_cnt, k + 1); else pass_cnt++;
    end
    drv = '0;
    cyc();
    total++; if (f_conf !== 1'b0) $display("FAIL conf_pulse_end got %b exp 0", f_conf); else pass_cnt++;
    total++; if (f_sticky !== 1'b1) $display("FAIL conf_sticky got %b exp 1", f_sticky); else pass_cnt++;
    total++; if (f_cnt !== 8'd3) $display("FAIL conf_count_hold got %0d exp 3", f_cnt); else pass_cnt++;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    total++; if (f_sticky !== 1'b0) $display("FAIL clr_sticky got %b exp 0", f_sticky); else pass_cnt++;
    total++; if (f_cnt !== 8'd0) $display("FAIL clr_count got %0d exp 0", f_cnt); else pass_cnt++;
    total++; if (s_cnt !== 2'd0) $display("FAIL clr_count_narrow got %0d exp 0", s_cnt); else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_s [5];
    exp_s[0] = 2'd1; exp_s[1] = 2'd2; exp_s[2] = 2'd3; exp_s[3] = 2'd3; exp_s[4] = 2'd3;
    drv = 9'b100000011;
    for (int k = 0; k < 5; k++) begin
      cyc();
      total++; if (s_cnt !== exp_s[k]) $display("FAIL sat_count[%0d] got %0d exp %0d", k, s_cnt, exp_s[k]); else pass_cnt++;
    end
    total++; if (f_cnt !== 8'd5) $display("FAIL wide_count got %0d exp 5", f_cnt); else pass_cnt++;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    total++; if (s_cnt !== 2'd1) $display("FAIL clr_during_conf_count got %0d exp 1", s_cnt); else pass_cnt++;
    total++; if (s_sticky !== 1'b1) $display("FAIL clr_during_conf_sticky got %b exp 1", s_sticky); else pass_cnt++;
    total++; if (f_cnt !== 8'd1) $display("FAIL clr_during_conf_wide got %0d exp 1", f_cnt); else pass_cnt++;
    total++; if (s_conf !== 1'b1) $display("FAIL clr_during_conf_pulse got %b exp 1", s_conf); else pass_cnt++;
  endtask

  task automatic test_idle_hold();
    drv = 9'b000100000;
    cyc();
    total++; if (f_owner !== 4'd5) $display("FAIL idle_pre_owner got %0d exp 5", f_owner); else pass_cnt++;
    drv = '0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      total++; if (f_data !== 36'd0) $display("FAIL idle_data[%0d] got %h exp 0", k, f_data); else pass_cnt++;
      total++; if (f_valid !== 1'b0) $display("FAIL idle_valid[%0d] got %b exp 0", k, f_valid); else pass_cnt++;
      total++; if (f_owner !== 4'd5) $display("FAIL idle_owner[%0d] got %0d exp 5", k, f_owner); else pass_cnt++;
    end
  endtask

  task automatic test_rr_hold();
    logic [8:0] seq_drv [8];
    logic [3:0] seq_own [8];
    rst_n = 1'b0; drv = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
    seq_drv[0] = 9'b000101010; seq_own[0] = 4'd1;
    seq_drv[1] = 9'b000101010; seq_own[1] = 4'd1;
    seq_drv[2] = 9'b000101010; seq_own[2] = 4'd1;
    seq_drv[3] = 9'b000101000; seq_own[3] = 4'd3;
    seq_drv[4] = 9'b000101010; seq_own[4] = 4'd3;
    seq_drv[5] = 9'b000100010; seq_own[5] = 4'd5;
    seq_drv[6] = 9'b000101010; seq_own[6] = 4'd5;
    seq_drv[7] = 9'b000001010; seq_own[7] = 4'd1;
    for (int k = 0; k < 8; k++) begin
      drv = seq_drv[k];
      cyc();
      total++; if (r_owner !== seq_own[k]) $display("FAIL rr_owner[%0d] got %0d exp %0d", k, r_owner, seq_own[k]); else pass_cnt++;
      total++; if (r_valid !== 1'b1) $display("FAIL rr_valid[%0d] got %b exp 1", k, r_valid); else pass_cnt++;
      total++; if (r_data !== dv[seq_own[k]]) $display("FAIL rr_data[%0d] got %h exp %h", k, r_data, dv[seq_own[k]]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    drv = 9'b010000000;
    cyc();
    cyc();
    total++; if (r_owner !== 4'd7) $display("FAIL mid_pre_owner got %0d exp 7", r_owner); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({r_valid, r_owner, r_data} !== 41'd0) $display("FAIL mid_async_out got %h exp 0", {r_valid, r_owner, r_data}); else pass_cnt++;
    total++; if ({r_conf, r_sticky, r_cnt} !== 10'd0) $display("FAIL mid_async_conf got %h exp 0", {r_conf, r_sticky, r_cnt}); else pass_cnt++;
    #2 rst_n = 1'b1;
    drv = 9'b010000001;
    cyc();
    total++; if (r_owner !== 4'd0) $display("FAIL mid_restart_owner got %0d exp 0", r_owner); else pass_cnt++;
    total++; if (r_data !== dv[0]) $display("FAIL mid_restart_data got %h exp %h", r_data, dv[0]); else pass_cnt++;
    total++; if (r_conf !== 1'b1) $display("FAIL mid_restart_conf got %b exp 1", r_conf); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    rst_n    = 1'b0;
    drv      = '0;
    clr      = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dv[i] = {4'(i), 32'hA5C3_0000 | 32'(i * 17)};
    end
    dv[4] = 36'o123456701234;
    for (int i = 0; i < 9; i++) begin
      drv_data[i*36 +: 36] = dv[i];
    end
    test_reset();
    test_fixed_single();
    test_fixed_conflict();
    test_saturate();
    test_idle_hold();
    test_rr_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
